buffer_escrita_dados: RTL and testbench

- Store buffer sitting directly upstream of the data memory's write port (`enderecoEscrita` / `dadoEscrita` / `memDadosControle`).
- Accepts CPU store requests into a small FIFO and drains one entry per cycle into data memory.
- Forwards buffered data to loads so reads stay coherent.
- Lets the core retire a store without waiting on the memory write port.

---
 rtl/buffer_escrita_dados_pkg.sv | 13 +
 rtl/buffer_escrita_dados_comparador.sv | 32 +++
 rtl/buffer_escrita_dados.sv | 122 ++++++++++++
 tb/tb_buffer_escrita_dados.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/buffer_escrita_dados_pkg.sv
// Shared memory-path widths and the store-buffer entry type.
// Imported by buffer_escrita_dados and comparador_encaminhamento.
package pacote_memoria;

  localparam int LARGURA_DADO = 32;
  localparam int LARGURA_END  = 32;

  typedef struct packed {
    logic [LARGURA_END-1:0]  endereco;
    logic [LARGURA_DADO-1:0] dado;
  } entrada_buffer_t;

endpackage

// File: rtl/buffer_escrita_dados_comparador.sv
// Load-forwarding comparator: finds the youngest valid buffered store whose
// address matches the load address. Purely combinational.
module comparador_encaminhamento
  import pacote_memoria::*;
#(
  parameter int PROFUNDIDADE = 4,
  localparam int LARGURA_PTR = $clog2(PROFUNDIDADE)
) (
  input  entrada_buffer_t          entradas [PROFUNDIDADE],
  input  logic [PROFUNDIDADE-1:0]  validas,
  input  logic [LARGURA_PTR-1:0]   ptrMaisAntigo,
  input  logic [LARGURA_END-1:0]   leituraEndereco,
  output logic                     acerto,
  output logic [LARGURA_DADO-1:0]  dado
);

  // Walk from oldest to youngest so the last match found wins.
  always_comb begin
    logic [LARGURA_PTR-1:0] idx;
    acerto = 1'b0;
    dado   = '0;
    idx    = '0;
    for (int k = 0; k < PROFUNDIDADE; k++) begin
      idx = ptrMaisAntigo + LARGURA_PTR'(k);
      if (validas[idx] && (entradas[idx].endereco == leituraEndereco)) begin
        acerto = 1'b1;
        dado   = entradas[idx].dado;
      end
    end
  end

endmodule

// File: rtl/buffer_escrita_dados.sv
// Store buffer in front of the data memory write port, with load forwarding.
// Optional same-address store merging into the youngest entry: BUFFER_ESCRITA_COALESCE_EN.
module buffer_escrita_dados #(
  parameter int PROFUNDIDADE = 4,
  parameter int LARGURA_DADO = 32,
  parameter int LARGURA_END  = 32
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    escritaValida,
  input  logic [LARGURA_END-1:0]  escritaEndereco,
  input  logic [LARGURA_DADO-1:0] escritaDado,
  output logic                    escritaPronta,
  input  logic [LARGURA_END-1:0]  leituraEndereco,
  input  logic [LARGURA_DADO-1:0] dadoLeituraMem,
  output logic [LARGURA_END-1:0]  enderecoLeitura,
  output logic [LARGURA_DADO-1:0] leituraDado,
  input  logic                    pausaMem,
  output logic [LARGURA_END-1:0]  enderecoEscrita,
  output logic [LARGURA_DADO-1:0] dadoEscrita,
  output logic                    memDadosControle,
  output logic                    vazio
);

  import pacote_memoria::entrada_buffer_t;

  localparam int LARGURA_PTR  = $clog2(PROFUNDIDADE);
  localparam int LARGURA_CONT = LARGURA_PTR + 1;

  entrada_buffer_t          fila [PROFUNDIDADE];
  logic [LARGURA_PTR-1:0]   ptrLeit;
  logic [LARGURA_PTR-1:0]   ptrEscr;
  logic [LARGURA_CONT-1:0]  contador;
  logic                     cheio;
  logic                     push;
  logic                     pop;
  logic                     coalesce;
  logic                     aloca;
  logic [PROFUNDIDADE-1:0]  validas;
  logic                     acerto;
  logic [LARGURA_DADO-1:0]  dadoEncaminhado;

  assign vazio            = (contador == '0);
  assign cheio            = (contador == LARGURA_CONT'(PROFUNDIDADE));
  assign memDadosControle = !vazio && !pausaMem && !reset;
  assign pop              = memDadosControle;

`ifdef BUFFER_ESCRITA_COALESCE_EN
  logic [LARGURA_PTR-1:0] ptrJovem;
  logic                   coalescivel;

  // The youngest entry may absorb a same-address store unless it is leaving now.
  assign ptrJovem      = ptrEscr - LARGURA_PTR'(1);
  assign coalescivel   = !vazio && (fila[ptrJovem].endereco == escritaEndereco)
                         && !((contador == LARGURA_CONT'(1)) && pop);
  assign escritaPronta = !cheio || (escritaValida && coalescivel);
  assign coalesce      = push && coalescivel;
`else
  assign escritaPronta = !cheio;
  assign coalesce      = 1'b0;
`endif

  assign push  = escritaValida && escritaPronta;
  assign aloca = push && !coalesce;

  // An entry is live when its distance from the head is below the count.
  always_comb begin
    logic [LARGURA_PTR-1:0] desloc;
    validas = '0;
    desloc  = '0;
    for (int i = 0; i < PROFUNDIDADE; i++) begin
      desloc     = LARGURA_PTR'(i) - ptrLeit;
      validas[i] = ({1'b0, desloc} < contador);
    end
  end

  comparador_encaminhamento #(
    .PROFUNDIDADE(PROFUNDIDADE)
  ) comparador (
    .entradas       (fila),
    .validas        (validas),
    .ptrMaisAntigo  (ptrLeit),
    .leituraEndereco(leituraEndereco),
    .acerto         (acerto),
    .dado           (dadoEncaminhado)
  );

  assign enderecoLeitura = leituraEndereco;
  assign leituraDado     = acerto ? dadoEncaminhado : dadoLeituraMem;
  assign enderecoEscrita = vazio ? '0 : fila[ptrLeit].endereco;
  assign dadoEscrita     = vazio ? '0 : fila[ptrLeit].dado;

  always_ff @(posedge clock) begin
    if (reset) begin
      ptrLeit  <= '0;
      ptrEscr  <= '0;
      contador <= '0;
    end else begin
      if (aloca) ptrEscr <= ptrEscr + LARGURA_PTR'(1);
      if (pop)   ptrLeit <= ptrLeit + LARGURA_PTR'(1);
      case ({aloca, pop})
        2'b10:   contador <= contador + LARGURA_CONT'(1);
        2'b01:   contador <= contador - LARGURA_CONT'(1);
        default: contador <= contador;
      endcase
    end
  end

  // Entry storage has no reset; the pointers alone define what is live.
  always_ff @(posedge clock) begin
    if (!reset) begin
      if (aloca) begin
        fila[ptrEscr] <= '{endereco: escritaEndereco, dado: escritaDado};
`ifdef BUFFER_ESCRITA_COALESCE_EN
      end else if (coalesce) begin
        fila[ptrJovem].dado <= escritaDado;
`endif
      end
    end
  end

endmodule

// File: tb/tb_buffer_escrita_dados.sv
// Self-checking bench for buffer_escrita_dados: queue-based reference model
// compared every cycle, plus directed literal checks of write order and forwarding.
module tb_buffer_escrita_dados;

  localparam int D = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        escritaValida;
  logic [31:0] escritaEndereco;
  logic [31:0] escritaDado;
  logic        escritaPronta;
  logic [31:0] leituraEndereco;
  logic [31:0] dadoLeituraMem;
  logic [31:0] enderecoLeitura;
  logic [31:0] leituraDado;
  logic        pausaMem;
  logic [31:0] enderecoEscrita;
  logic [31:0] dadoEscrita;
  logic        memDadosControle;
  logic        vazio;

  always #5 clock = ~clock;

  buffer_escrita_dados #(
    .PROFUNDIDADE(D),
    .LARGURA_DADO(32),
    .LARGURA_END (32)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .escritaValida   (escritaValida),
    .escritaEndereco (escritaEndereco),
    .escritaDado     (escritaDado),
    .escritaPronta   (escritaPronta),
    .leituraEndereco (leituraEndereco),
    .dadoLeituraMem  (dadoLeituraMem),
    .enderecoLeitura (enderecoLeitura),
    .leituraDado     (leituraDado),
    .pausaMem        (pausaMem),
    .enderecoEscrita (enderecoEscrita),
    .dadoEscrita     (dadoEscrita),
    .memDadosControle(memDadosControle),
    .vazio           (vazio)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } par_t;

  par_t modelo[$];
  par_t dutLog[$];
  int   passCount  = 0;
  int   checkCount = 0;
  bit   checkEn    = 1'b0;
  int   base;

  task automatic checkOutput(input string nome, input logic [63:0] atual, input logic [63:0] esperado);
    checkCount++;
    if (atual === esperado) passCount++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", nome, atual, esperado);
  endtask

  function automatic bit coalescivelModelo();
`ifdef BUFFER_ESCRITA_COALESCE_EN
    bit saiAgora;
    saiAgora = (modelo.size() != 0) && !pausaMem && !reset;
    return (modelo.size() != 0) && (modelo[modelo.size()-1].a == escritaEndereco)
           && !((modelo.size() == 1) && saiAgora);
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit prontaModelo();
    return (modelo.size() != D) || (escritaValida && coalescivelModelo());
  endfunction

  function automatic logic [31:0] leituraModelo();
    for (int k = modelo.size() - 1; k >= 0; k--)
      if (modelo[k].a == leituraEndereco) return modelo[k].d;
    return dadoLeituraMem;
  endfunction

  // Reference model: FIFO of stores, one leaves per unpaused cycle.
  always @(posedge clock) begin
    bit popM, pushM, coalM;
    if (reset) begin
      modelo.delete();
    end else begin
      popM  = (modelo.size() != 0) && !pausaMem;
      pushM = escritaValida && prontaModelo();
      coalM = pushM && coalescivelModelo();
      if (coalM) modelo[modelo.size()-1].d = escritaDado;
      if (popM) void'(modelo.pop_front());
      if (pushM && !coalM) modelo.push_back('{escritaEndereco, escritaDado});
    end
  end

  always @(negedge clock) begin
    if (checkEn) begin
      checkOutput("escritaPronta", escritaPronta, prontaModelo());
      checkOutput("vazio", vazio, modelo.size() == 0);
      checkOutput("memDadosControle", memDadosControle, (modelo.size() != 0) && !pausaMem && !reset);
      checkOutput("enderecoEscrita", enderecoEscrita, (modelo.size() != 0) ? modelo[0].a : 32'h0);
      checkOutput("dadoEscrita", dadoEscrita, (modelo.size() != 0) ? modelo[0].d : 32'h0);
      checkOutput("leituraDado", leituraDado, leituraModelo());
      checkOutput("enderecoLeitura", enderecoLeitura, leituraEndereco);
      if (memDadosControle === 1'b1) dutLog.push_back('{enderecoEscrita, dadoEscrita});
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input bit v, input logic [31:0] a, input logic [31:0] d, input bit p);
    escritaValida   = v;
    escritaEndereco = a;
    escritaDado     = d;
    pausaMem        = p;
    tick();
    escritaValida = 1'b0;
  endtask

  task automatic drainAll();
    pausaMem      = 1'b0;
    escritaValida = 1'b0;
    for (int c = 0; c < 20 && vazio !== 1'b1; c++) tick();
    checkOutput("drainBound", vazio, 1'b1);
  endtask

  initial begin
    reset = 1'b1; escritaValida = 1'b0; pausaMem = 1'b0;
    escritaEndereco = '0; escritaDado = '0; leituraEndereco = '0; dadoLeituraMem = '0;
    tick();
    checkEn = 1'b1;
    tick();
    reset = 1'b0;
    checkOutput("rstPronta", escritaPronta, 1'b1);
    checkOutput("rstVazio", vazio, 1'b1);
    checkOutput("rstWe", memDadosControle, 1'b0);
    checkOutput("rstEnd", enderecoEscrita, 32'h0);
    checkOutput("rstDado", dadoEscrita, 32'h0);

    // Single store reaches memory one cycle after it is accepted.
    applyStimulus(1'b1, 32'h5, 32'hAAAA0001, 1'b0);
    checkOutput("t1We", memDadosControle, 1'b1);
    checkOutput("t1End", enderecoEscrita, 32'h5);
    checkOutput("t1Dado", dadoEscrita, 32'hAAAA0001);
    tick();
    checkOutput("t1Vazio", vazio, 1'b1);

    // Fill while paused, overflow ignored, then FIFO-ordered drain.
    base = dutLog.size();
    for (int k = 1; k <= 4; k++) applyStimulus(1'b1, 32'(k), 32'hB0 + 32'(k), 1'b1);
    checkOutput("t2Cheio", escritaPronta, 1'b0);
    applyStimulus(1'b1, 32'h5, 32'hB5, 1'b1);
    checkOutput("t2CheioAposExtra", escritaPronta, 1'b0);
    pausaMem = 1'b0;
    repeat (4) tick();
    checkOutput("t2NumEscritas", dutLog.size() - base, 4);
    for (int k = 0; k < 4 && base + k < dutLog.size(); k++) begin
      checkOutput("t2OrdemEnd", dutLog[base+k].a, 32'(k + 1));
      checkOutput("t2OrdemDado", dutLog[base+k].d, 32'hB1 + 32'(k));
    end
    checkOutput("t2ProntaFinal", escritaPronta, 1'b1);
    checkOutput("t2VazioFinal", vazio, 1'b1);

    // Youngest match forwards; a store pushed this cycle does not.
    applyStimulus(1'b1, 32'h7, 32'h11, 1'b1);
    applyStimulus(1'b1, 32'h7, 32'h22, 1'b1);
    leituraEndereco = 32'h7; dadoLeituraMem = 32'hFFFF; #1;
    checkOutput("t3Jovem", leituraDado, 32'h22);
    leituraEndereco = 32'h8; #1;
    checkOutput("t3SemAcerto", leituraDado, 32'hFFFF);
    escritaValida = 1'b1; escritaEndereco = 32'h30; escritaDado = 32'h55;
    leituraEndereco = 32'h30; dadoLeituraMem = 32'h77; #1;
    checkOutput("t3MesmoCiclo", leituraDado, 32'h77);
    tick();
    escritaValida = 1'b0;
    checkOutput("t3CicloSeguinte", leituraDado, 32'h55);
    drainAll();

    // Full buffer with push and pop in the same cycle: push is refused.
    base = dutLog.size();
    for (int k = 0; k < 4; k++) applyStimulus(1'b1, 32'h10 + 32'(k), 32'hC0 + 32'(k), 1'b1);
    applyStimulus(1'b1, 32'h20, 32'h99, 1'b0);
    checkOutput("t4ProntaApos", escritaPronta, 1'b1);
    drainAll();
    checkOutput("t4NumEscritas", dutLog.size() - base, 4);
    if (dutLog.size() > 0) checkOutput("t4Ultimo", dutLog[dutLog.size()-1].a, 32'h13);
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 4; k++)
        applyStimulus(1'b1, 32'h100 * 32'(r + 1) + 32'(k), 32'(r * 16 + k), 1'b1);
      checkOutput("t4WrapCheio", escritaPronta, 1'b0);
      drainAll();
    end

    // Reset during a drain discards everything still pending.
    for (int k = 0; k < 3; k++) applyStimulus(1'b1, 32'h40 + 32'(k), 32'hD0 + 32'(k), 1'b1);
    pausaMem = 1'b0; reset = 1'b1; #1;
    checkOutput("t5WeEmReset", memDadosControle, 1'b0);
    base = dutLog.size();
    tick();
    reset = 1'b0;
    checkOutput("t5Vazio", vazio, 1'b1);
    checkOutput("t5We", memDadosControle, 1'b0);
    repeat (3) tick();
    checkOutput("t5SemEscritas", dutLog.size() - base, 0);

    // Two stores to the same address: merged or kept separate by build option.
    base = dutLog.size();
    applyStimulus(1'b1, 32'h9, 32'h1, 1'b1);
    applyStimulus(1'b1, 32'h9, 32'h2, 1'b1);
    drainAll();
`ifdef BUFFER_ESCRITA_COALESCE_EN
    checkOutput("t6NumEscritas", dutLog.size() - base, 1);
    if (dutLog.size() > base) checkOutput("t6Dado", dutLog[base].d, 32'h2);
`else
    checkOutput("t6NumEscritas", dutLog.size() - base, 2);
    if (dutLog.size() > base + 1) begin
      checkOutput("t6Dado0", dutLog[base].d, 32'h1);
      checkOutput("t6Dado1", dutLog[base+1].d, 32'h2);
    end
`endif

    checkEn = 1'b0;
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
